// File: rtl/cal_pkg.sv
// Shared types and constants for the calibration sequencer.
package cal_pkg;

  // Sequencer states: conversion handshake, four fetch/execute step pairs, terminal states.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CNV,
    S_WAIT,
    S_F0,
    S_X0,
    S_F1,
    S_X1,
    S_F2,
    S_X2,
    S_F3,
    S_X3,
    S_DONE,
    S_ERR
  } state_t;

  // NV_MEM coefficient indices, one per recipe step.
  localparam logic [1:0] C_OFS0  = 2'd0;
  localparam logic [1:0] C_GAIN1 = 2'd1;
  localparam logic [1:0] C_OFS2  = 2'd2;
  localparam logic [1:0] C_GAIN3 = 2'd3;

  localparam int NUM_STEPS = 4;

endpackage

// File: rtl/cal_seq_if.sv
// Control bundle between the calibration sequencer and its environment
// (A2D converter, NV_MEM and the calibration datapath).
interface cal_seq_if;
  logic       strt_cal;
  logic       cnv_cmplt;
  logic       strt_cnv;
  logic [1:0] addr;
  logic       selA2D;
  logic       selCoeff;
  logic       selMult;
  logic       enTmp;
  logic       busy;
  logic       cal_done;
  logic       cal_err;

  // Sequencer side: it initiates every datapath operation.
  modport master (
    input  strt_cal, cnv_cmplt,
    output strt_cnv, addr, selA2D, selCoeff, selMult, enTmp, busy, cal_done, cal_err
  );

  // Environment side.
  modport slave (
    output strt_cal, cnv_cmplt,
    input  strt_cnv, addr, selA2D, selCoeff, selMult, enTmp, busy, cal_done, cal_err
  );
endinterface

// File: rtl/cal_tmr.sv
// Clearable saturating up-counter with a terminal-count flag, used to bound
// the wait for the A2D conversion. Counts 0..TIMEOUT_CYC-1 and holds there.
module cal_tmr #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // Count up while enabled, stop at the limit, clear on request.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LIMIT);

endmodule

// File: rtl/cal_seq.sv
// Calibration control sequencer: starts an A2D conversion, waits (bounded)
// for it to complete, then steps the four-operation recipe
// (add offset, multiply gain, add offset, multiply gain). Each step is a
// fetch cycle (coefficient address presented to the synchronous NV_MEM)
// followed by an execute cycle (coefficient valid, Temp written).
// All outputs are a Moore decode of the state register.
module cal_seq
  import cal_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic      clk,
  input  logic      rst_n,
  cal_seq_if.master bus
);

  state_t state;
  state_t state_nxt;
  logic   tmr_clr;
  logic   tmr_inc;
  logic   tmr_tc;

  cal_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .inc  (tmr_inc),
    .tc   (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; the timer only runs in WAIT and is held clear elsewhere.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    tmr_clr      = 1'b1;
    tmr_inc      = 1'b0;
    bus.strt_cnv = 1'b0;
    bus.addr     = C_OFS0;
    bus.selA2D   = 1'b0;
    bus.selCoeff = 1'b0;
    bus.selMult  = 1'b0;
    bus.enTmp    = 1'b0;
    bus.busy     = (state != S_IDLE);
    bus.cal_done = 1'b0;
    bus.cal_err  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.strt_cal) state_nxt = S_CNV;
      end
      S_CNV: begin
        bus.strt_cnv = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b1;
        // A completion on the limit cycle still counts as success.
        if (bus.cnv_cmplt)   state_nxt = S_F0;
        else if (tmr_tc)     state_nxt = S_ERR;
      end
      S_F0: begin
        bus.addr  = C_OFS0;
        state_nxt = S_X0;
      end
      S_X0: begin
        // Temp <- a2d + offset
        bus.addr     = C_OFS0;
        bus.selA2D   = 1'b1;
        bus.selCoeff = 1'b1;
        bus.enTmp    = 1'b1;
        state_nxt    = S_F1;
      end
      S_F1: begin
        bus.addr  = C_GAIN1;
        state_nxt = S_X1;
      end
      S_X1: begin
        // Temp <- Temp * gain
        bus.addr    = C_GAIN1;
        bus.selMult = 1'b1;
        bus.enTmp   = 1'b1;
        state_nxt   = S_F2;
      end
      S_F2: begin
        bus.addr  = C_OFS2;
        state_nxt = S_X2;
      end
      S_X2: begin
        // Temp <- Temp + offset
        bus.addr     = C_OFS2;
        bus.selCoeff = 1'b1;
        bus.enTmp    = 1'b1;
        state_nxt    = S_F3;
      end
      S_F3: begin
        bus.addr  = C_GAIN3;
        state_nxt = S_X3;
      end
      S_X3: begin
        // Temp <- Temp * gain
        bus.addr    = C_GAIN3;
        bus.selMult = 1'b1;
        bus.enTmp   = 1'b1;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        bus.cal_done = 1'b1;
        state_nxt    = S_IDLE;
      end
      S_ERR: begin
        bus.cal_err = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cal_seq.sv
// Self-checking bench for cal_seq. Two instances: TIMEOUT_CYC=8 (main runs,
// attached to a small NV_MEM + datapath model) and TIMEOUT_CYC=4 (limit-edge case).
// Expected per-cycle output vectors are queued when stimulus is driven and
// compared one per cycle on the falling edge.
module tb_cal_seq;

  typedef struct packed {
    logic       cnv;
    logic       busy;
    logic [1:0] addr;
    logic       sel_a;
    logic       sel_c;
    logic       sel_m;
    logic       en;
    logic       done;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic strt_cal  = 1'b0;
  logic cnv_cmplt = 1'b0;
  logic sel4      = 1'b0;

  cal_seq_if if8 ();
  cal_seq_if if4 ();

  assign if8.strt_cal  = sel4 ? 1'b0 : strt_cal;
  assign if8.cnv_cmplt = sel4 ? 1'b0 : cnv_cmplt;
  assign if4.strt_cal  = sel4 ? strt_cal : 1'b0;
  assign if4.cnv_cmplt = sel4 ? cnv_cmplt : 1'b0;

  cal_seq #(.TIMEOUT_CYC(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  cal_seq #(.TIMEOUT_CYC(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // NV_MEM + datapath model: unsigned 16-bit, gain format has 12 fractional bits.
  localparam logic [15:0] A2D   = 16'h0100;
  localparam logic [15:0] UNITY = 16'h1000;
  logic [15:0] nv_mem [4] = '{16'h0010, UNITY, 16'h0004, UNITY};
  logic [15:0] coeff = '0;
  logic [15:0] temp  = '0;
  logic [15:0] a_side, b_side, dp_res;
  logic [31:0] prod, sum;

  always_comb begin
    a_side = if8.selA2D ? A2D : temp;
    b_side = if8.selCoeff ? coeff : 16'h0000;
    prod   = ({16'h0000, a_side} * {16'h0000, coeff}) >> 12;
    sum    = {16'h0000, a_side} + {16'h0000, b_side};
    if (if8.selMult) dp_res = (prod > 32'h0000_FFFF) ? 16'hFFFF : prod[15:0];
    else             dp_res = (sum  > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
  end

  always @(posedge clk) begin
    coeff <= nv_mem[if8.addr];
    if (if8.enTmp) temp <= dp_res;
  end

  exp_t        exp_q [$];
  logic [15:0] temp_q [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc_idx = 0;
  string       cur_test = "init";

  function automatic exp_t mk(logic cnv, logic busy, logic [1:0] addr, logic a, logic c,
                              logic m, logic en, logic done, logic err);
    exp_t e;
    e.cnv = cnv; e.busy = busy; e.addr = addr; e.sel_a = a; e.sel_c = c;
    e.sel_m = m; e.en = en; e.done = done; e.err = err;
    return e;
  endfunction

  function automatic exp_t v_idle();  return mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t v_cnv();   return mk(1, 1, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t v_wait();  return mk(0, 1, 2'd0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t v_done();  return mk(0, 1, 2'd0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic exp_t v_err();   return mk(0, 1, 2'd0, 0, 0, 0, 0, 0, 1); endfunction
  function automatic exp_t v_f(logic [1:0] k); return mk(0, 1, k, 0, 0, 0, 0, 0, 0); endfunction
  function automatic exp_t v_x(logic [1:0] k);
    case (k)
      2'd0:    return mk(0, 1, k, 1, 1, 0, 1, 0, 0);
      2'd2:    return mk(0, 1, k, 0, 1, 0, 1, 0, 0);
      default: return mk(0, 1, k, 0, 0, 1, 1, 0, 0);
    endcase
  endfunction

  function automatic exp_t vec_of(logic use4);
    exp_t g;
    if (use4) g = {if4.strt_cnv, if4.busy, if4.addr, if4.selA2D, if4.selCoeff,
                   if4.selMult, if4.enTmp, if4.cal_done, if4.cal_err};
    else      g = {if8.strt_cnv, if8.busy, if8.addr, if8.selA2D, if8.selCoeff,
                   if8.selMult, if8.enTmp, if8.cal_done, if8.cal_err};
    return g;
  endfunction

  // Full recipe after an accepted cnv_cmplt: F0..X3, DONE, then back to IDLE.
  task automatic push_recipe();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(v_f(k[1:0]));
      exp_q.push_back(v_x(k[1:0]));
    end
    exp_q.push_back(v_done());
    exp_q.push_back(v_idle());
  endtask

  // Advance one cycle and compare the selected DUT against the next queued vector.
  task automatic obs_cycle();
    exp_t got;
    exp_t want;
    logic [15:0] t_want;
    @(negedge clk);
    got = vec_of(sel4);
    cyc_idx++;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s[%0d] no expected vector queued, got=%b", cur_test, cyc_idx, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want)
        begin
          bad++;
          $display("FAIL %s[%0d] outputs {cnv,busy,addr,a,c,m,en,done,err} got=%b want=%b",
                   cur_test, cyc_idx, got, want);
        end
    end
    if (!sel4 && got.done === 1'b1 && temp_q.size() != 0) begin
      t_want = temp_q.pop_front();
      total++;
      if (temp !== t_want) begin
        bad++;
        $display("FAIL %s[%0d] temp at cal_done got=%h want=%h", cur_test, cyc_idx, temp, t_want);
      end
    end
  endtask

  // One complete run: strt_cal, n_wait WAIT cycles, cnv_cmplt in the last one.
  task automatic run_to_done(int n_wait, logic chk_temp);
    strt_cal = 1'b1;
    exp_q.push_back(v_cnv());
    if (chk_temp) temp_q.push_back(16'h0114);
    obs_cycle();
    strt_cal = 1'b0;
    for (int i = 0; i < n_wait; i++) begin
      exp_q.push_back(v_wait());
      obs_cycle();
    end
    cnv_cmplt = 1'b1;
    push_recipe();
    obs_cycle();
    cnv_cmplt = 1'b0;
    repeat (9) obs_cycle();
  endtask

  task automatic test_reset();
    exp_t g;
    cur_test = "reset";
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g = vec_of(d[0]);
      total++;
      if (g !== v_idle()) begin
        bad++;
        $display("FAIL reset dut%0d outputs got=%b want=%b", d, g, v_idle());
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(v_idle());
    obs_cycle();
  endtask

  task automatic test_nominal();
    cur_test = "nominal";
    run_to_done(5, 1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t g;
    cur_test = "reset_mid";
    strt_cal = 1'b1;
    exp_q.push_back(v_cnv());
    obs_cycle();
    strt_cal = 1'b0;
    exp_q.push_back(v_wait());
    obs_cycle();
    cnv_cmplt = 1'b1;
    push_recipe();
    obs_cycle();
    cnv_cmplt = 1'b0;
    repeat (3) obs_cycle();  // now in X1
    rst_n = 1'b0;
    #1;
    g = vec_of(1'b0);
    total++;
    if (g !== v_idle()) begin
      bad++;
      $display("FAIL reset_mid immediate outputs got=%b want=%b", g, v_idle());
    end
    @(negedge clk);
    g = vec_of(1'b0);
    total++;
    if (g !== v_idle()) begin
      bad++;
      $display("FAIL reset_mid held outputs got=%b want=%b", g, v_idle());
    end
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(v_idle());
    obs_cycle();
    cur_test = "after_reset";
    run_to_done(2, 1'b1);
  endtask

  task automatic test_timeout();
    cur_test = "timeout";
    strt_cal = 1'b1;
    exp_q.push_back(v_cnv());
    obs_cycle();
    strt_cal = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(v_wait());
    exp_q.push_back(v_err());
    exp_q.push_back(v_idle());
    exp_q.push_back(v_idle());
    repeat (11) obs_cycle();
  endtask

  task automatic test_strt_spam();
    cur_test = "strt_spam";
    cnv_cmplt = 1'b1;                      // ignored in IDLE
    exp_q.push_back(v_idle());
    exp_q.push_back(v_idle());
    repeat (2) obs_cycle();
    cnv_cmplt = 1'b0;
    strt_cal = 1'b1;                       // held for the whole run
    exp_q.push_back(v_cnv());
    temp_q.push_back(16'h0114);
    obs_cycle();
    exp_q.push_back(v_wait());
    exp_q.push_back(v_wait());
    repeat (2) obs_cycle();
    cnv_cmplt = 1'b1;                      // stays high into F/X: ignored there
    push_recipe();
    void'(exp_q.pop_back());               // DONE is followed by one IDLE then a new CNV
    exp_q.push_back(v_idle());
    exp_q.push_back(v_cnv());
    repeat (4) obs_cycle();
    cnv_cmplt = 1'b0;
    repeat (7) obs_cycle();                // through DONE, IDLE, second CNV
    strt_cal = 1'b0;
    temp_q.push_back(16'h0114);
    exp_q.push_back(v_wait());
    obs_cycle();
    cnv_cmplt = 1'b1;
    push_recipe();
    obs_cycle();
    cnv_cmplt = 1'b0;
    repeat (9) obs_cycle();
  endtask

  task automatic test_tmo_edge();
    cur_test = "tmo_edge";
    sel4 = 1'b1;
    run_to_done(4, 1'b0);                  // cnv_cmplt on the 4th WAIT cycle = limit
    sel4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid();
    test_timeout();
    test_strt_spam();
    test_tmo_edge();
    total++;
    if (exp_q.size() != 0 || temp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover expectations exp=%0d temp=%0d want=0", exp_q.size(), temp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
